tft_ctrl: RTL
=============

Name: tft_ctrl

Overview:
- Sequencer in front of `tft_spi`: the only block that drives its `data`/`dc`/`transmit` inputs and watches its `busy` output.
- After reset it performs the panel bring-up:
  - hardware reset pulse,
  - fixed init command list with power-up delays.
- It then serves rectangle-fill requests from the game/render logic:
  - sets the panel address window (CASET/RASET),
  - issues RAMWR,
  - streams one RGB565 colour for every pixel in the window.

Parameters:
- RST_CYCLES, 1000: cycles `tft_rst` is held low, and the wait after its release.
- DELAY_CYCLES, 1200000: wait after SWRESET and after SLPOUT (120 ms at 10 MHz).

Ports:
- clk  in  1  system clock; same clock as `tft_spi`.
- global_reset  in  1  asynchronous, active-high reset.
- spi_data  out  8  byte to `tft_spi.data`.
- spi_dc  out  1  to `tft_spi.dc`; 0 = command, 1 = data.
- spi_transmit  out  1  one-cycle start pulse to `tft_spi.transmit`.
- spi_busy  in  1  from `tft_spi.busy`.
- tft_rst  out  1  panel hardware reset, active low.
- fill_req  in  1  fill request; sampled only while `fill_ready`=1.
- fill_x0, fill_y0, fill_x1, fill_y1  in  8 each  inclusive window corners.
- fill_color  in  16  RGB565 colour.
- fill_ready  out  1  idle; accepts `fill_req`.
- fill_done  out  1  one-cycle pulse after the last byte of a fill completes.
- fill_err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset values (asynchronous):
  - `tft_rst`=0; `spi_transmit`=0; `spi_data`=0; `spi_dc`=0.
  - `fill_ready`=0; `fill_done`=0; `fill_err`=0.
  - All counters cleared; state = RST_LOW.
- Reset mid-operation aborts immediately; no partial fill resumes. `tft_spi` shares `global_reset`, so both restart together.
- Byte issue sub-sequence, used for every byte:
  - ISSUE: wait until `spi_busy`=0. Then drive `spi_data`/`spi_dc` and pulse `spi_transmit` for exactly one cycle.
  - SKIP: one cycle, ignore `spi_busy`. `tft_spi` raises `busy` only on the following edge.
  - WAIT: wait until `spi_busy`=0, then advance to the next byte/state.
  - `spi_data`/`spi_dc` hold their value from the ISSUE cycle until the next ISSUE.
  - `spi_transmit` is never high on two consecutive cycles.
- Bring-up state machine:
  - RST_LOW: `tft_rst`=0 for RST_CYCLES cycles.
  - RST_WAIT: `tft_rst`=1 (stays 1 until the next reset) for RST_CYCLES cycles.
  - INIT: walk the internal ROM:
    - 0x01 C, then delay DELAY_CYCLES;
    - 0x11 C, then delay DELAY_CYCLES;
    - 0x3A C, 0x05 D;
    - 0x36 C, 0x00 D;
    - 0x29 C.
    - Total 7 bytes (C: `dc`=0, D: `dc`=1).
    - Delays start after WAIT sees `busy`=0 for that command.
  - IDLE: `fill_ready`=1.
- Fill acceptance:
  - In IDLE with `fill_req`=1, latch all coordinates and the colour; `fill_ready` drops the next cycle.
  - If `x1<x0` or `y1<y0`: pulse `fill_err` one cycle, stay in IDLE, send no bytes.
  - `fill_req` is ignored while `fill_ready`=0; no queueing.
- Fill sequence, 11 setup bytes:
  - 0x2A C, 0x00 D, x0 D, 0x00 D, x1 D;
  - 0x2B C, 0x00 D, y0 D, 0x00 D, y1 D;
  - 0x2C C.
- Pixel stream:
  - Pixel count N = (x1-x0+1)·(y1-y0+1), computed in 17 bits (max 65536).
  - For each pixel send `color[15:8]` D, then `color[7:0]` D; 2N bytes total.
  - The pixel counter decrements after each low byte.
  - On the last low byte's WAIT exit: pulse `fill_done` one cycle and return to IDLE. `fill_ready`=1 in the same cycle as `fill_done`.
- Boundaries:
  - A single-pixel window (x0=x1, y0=y1) gives N=1.
  - The full 256×256 window gives N=65536 with no counter wrap.

Test Plan:
- Assert reset, release, model `tft_spi` with an 8-cycle busy -> `tft_rst` low exactly RST_CYCLES, then high. Byte log (data/dc) = 01/0, 11/0, 3A/0, 05/1, 36/0, 00/1, 29/0. Gaps ≥DELAY_CYCLES after 01 and 11. `fill_ready` rises after 29 completes.
- Fill x0=2,y0=3,x1=3,y1=4,color=0xF81F -> 19 bytes: 2A,00,02,00,03, 2B,00,03,00,04, 2C, then F8,1F ×4. Only 2A/2B/2C have dc=0. One `fill_done` pulse after the final 1F.
- Fill with x0=5,x1=4 -> `fill_err` one cycle, zero `spi_transmit` pulses, `fill_ready` stays 1.
- Hold `fill_req`=1 throughout a fill, with a different colour asserted during the stream -> second request accepted only after `fill_done`. Colour latched at acceptance unchanged mid-stream.
- Assert `global_reset` during the pixel stream -> `spi_transmit`=0 and `tft_rst`=0 immediately (asynchronously). Full bring-up repeats from RST_LOW.
- Protocol checker across all tests -> `spi_transmit` never high while `spi_busy`=1 or on consecutive cycles. Data is stable between issues.

Source files
------------

// File: rtl/tft_ctrl.sv
// tft_ctrl: panel bring-up and rectangle-fill sequencer driving tft_spi.
// Each byte is issued, given one blind cycle, then waited out on busy.
module tft_ctrl #(
  parameter int unsigned RST_CYCLES   = 1000,
  parameter int unsigned DELAY_CYCLES = 1200000
) (
  input  logic        clk,
  input  logic        global_reset,
  output logic [7:0]  spi_data,
  output logic        spi_dc,
  output logic        spi_transmit,
  input  logic        spi_busy,
  output logic        tft_rst,
  input  logic        fill_req,
  input  logic [7:0]  fill_x0,
  input  logic [7:0]  fill_y0,
  input  logic [7:0]  fill_x1,
  input  logic [7:0]  fill_y1,
  input  logic [15:0] fill_color,
  output logic        fill_ready,
  output logic        fill_done,
  output logic        fill_err
);

  typedef enum logic [2:0] {
    S_RST_LOW, S_RST_WAIT, S_INIT, S_DELAY,
    S_IDLE, S_SETUP, S_PIX
  } state_e;

  typedef enum logic [1:0] {P_ISSUE, P_SKIP, P_WAIT} phase_e;

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [16:0] pix_q, pix_d;
  logic        hi_q, hi_d;
  logic [7:0]  x0_q, x0_d, y0_q, y0_d;
  logic [7:0]  x1_q, x1_d, y1_q, y1_d;
  logic [15:0] color_q, color_d;
  logic [7:0]  data_q, data_d;
  logic        dc_q, dc_d;
  logic        tx_q, tx_d;
  logic        nrst_q, nrst_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        byte_done;
  logic [7:0]  cur_data;
  logic        cur_dc;
  logic        bad_req;
  logic [16:0] w, h, npix;

  assign bad_req = (fill_x1 < fill_x0) || (fill_y1 < fill_y0);
  assign w       = {9'd0, fill_x1} - {9'd0, fill_x0} + 17'd1;
  assign h       = {9'd0, fill_y1} - {9'd0, fill_y0} + 17'd1;
  // 256*256 = 65536 still fits in 17 bits
  assign npix    = w * h;

  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      state_q <= S_RST_LOW;
      phase_q <= P_ISSUE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pix_q   <= '0;
      hi_q    <= 1'b1;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      data_q  <= '0;
      dc_q    <= 1'b0;
      tx_q    <= 1'b0;
      nrst_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      hi_q    <= hi_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
      tx_q    <= tx_d;
      nrst_q  <= nrst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    cur_data = 8'h00;
    cur_dc   = 1'b1;
    case (state_q)
      S_INIT: begin
        unique case (idx_q)
          4'd0:    {cur_data, cur_dc} = {8'h01, 1'b0};
          4'd1:    {cur_data, cur_dc} = {8'h11, 1'b0};
          4'd2:    {cur_data, cur_dc} = {8'h3A, 1'b0};
          4'd3:    {cur_data, cur_dc} = {8'h05, 1'b1};
          4'd4:    {cur_data, cur_dc} = {8'h36, 1'b0};
          4'd5:    {cur_data, cur_dc} = {8'h00, 1'b1};
          default: {cur_data, cur_dc} = {8'h29, 1'b0};
        endcase
      end
      S_SETUP: begin
        unique case (idx_q)
          4'd0:    {cur_data, cur_dc} = {8'h2A, 1'b0};
          4'd2:    cur_data = x0_q;
          4'd4:    cur_data = x1_q;
          4'd5:    {cur_data, cur_dc} = {8'h2B, 1'b0};
          4'd7:    cur_data = y0_q;
          4'd9:    cur_data = y1_q;
          4'd10:   {cur_data, cur_dc} = {8'h2C, 1'b0};
          default: cur_data = 8'h00;
        endcase
      end
      S_PIX:   cur_data = hi_q ? color_q[15:8] : color_q[7:0];
      default: cur_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pix_d     = pix_q;
    hi_d      = hi_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    color_d   = color_q;
    data_d    = data_q;
    dc_d      = dc_q;
    tx_d      = 1'b0;
    nrst_d    = nrst_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    byte_done = 1'b0;

    if (state_q inside {S_INIT, S_SETUP, S_PIX}) begin
      unique case (phase_q)
        P_ISSUE: if (!spi_busy) begin
          tx_d    = 1'b1;
          data_d  = cur_data;
          dc_d    = cur_dc;
          phase_d = P_SKIP;
        end
        P_SKIP:  phase_d = P_WAIT;
        P_WAIT: if (!spi_busy) begin
          phase_d   = P_ISSUE;
          byte_done = 1'b1;
        end
        default: phase_d = P_ISSUE;
      endcase
    end

    case (state_q)
      S_RST_LOW: begin
        if (cnt_q == RST_CYCLES - 1) begin
          cnt_d   = '0;
          nrst_d  = 1'b1;
          state_d = S_RST_WAIT;
        end else cnt_d = cnt_q + 32'd1;
      end
      S_RST_WAIT: begin
        if (cnt_q == RST_CYCLES - 1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_INIT;
        end else cnt_d = cnt_q + 32'd1;
      end
      S_INIT: if (byte_done) begin
        if (idx_q == 4'd0 || idx_q == 4'd1) state_d = S_DELAY;
        else if (idx_q == 4'd6) state_d = S_IDLE;
        else idx_d = idx_q + 4'd1;
      end
      S_DELAY: begin
        if (cnt_q == DELAY_CYCLES - 1) begin
          cnt_d   = '0;
          idx_d   = idx_q + 4'd1;
          state_d = S_INIT;
        end else cnt_d = cnt_q + 32'd1;
      end
      S_IDLE: if (fill_req) begin
        if (bad_req) err_d = 1'b1;
        else begin
          x0_d    = fill_x0;
          y0_d    = fill_y0;
          x1_d    = fill_x1;
          y1_d    = fill_y1;
          color_d = fill_color;
          pix_d   = npix;
          idx_d   = '0;
          hi_d    = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: if (byte_done) begin
        if (idx_q == 4'd10) state_d = S_PIX;
        else idx_d = idx_q + 4'd1;
      end
      S_PIX: if (byte_done) begin
        if (hi_q) hi_d = 1'b0;
        else begin
          hi_d  = 1'b1;
          pix_d = pix_q - 17'd1;
          if (pix_q == 17'd1) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_RST_LOW;
    endcase
  end

  always_comb begin
    spi_data     = data_q;
    spi_dc       = dc_q;
    spi_transmit = tx_q;
    tft_rst      = nrst_q;
    fill_ready   = (state_q == S_IDLE);
    fill_done    = done_q;
    fill_err     = err_q;
  end

endmodule
